debounce_multi: RTL and testbench

//  N-channel debouncer for GPIO/button/trigger inputs. Successor of the single-channel debouncer.
//  Per-channel enable, length and mode:
//   - LOCKOUT: follow the first edge, then ignore the input for len cycles.
//   - STABLE: change only after the input has been steady for len+1 cycles.

---
 rtl/debounce_pkg.sv | 9 +
 rtl/debounce_ch.sv | 85 ++++++++
 rtl/debounce_multi.sv | 45 ++++
 tb/tb_debounce_multi.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic {
        LOCKOUT = 1'b0,
        STABLE  = 1'b1
    } mode_t;

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: input synchronizer, lockout/stable counter,
// debounced output with edge pulses and sticky edge flags.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned CW = 8,
    parameter int unsigned SS = 2,
    parameter logic        DI = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  mode_t         mode,
    input  logic [CW-1:0] len,
    input  logic          clr,
    input  logic          d_i,
    output logic          d_o,
    output logic          d_p,
    output logic          d_n,
    output logic          evt_p,
    output logic          evt_n
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [SS-1:0] sync_q;
    logic          s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          do_nxt;
    mode_t         mode_r;

    assign s = sync_q[SS-1];

    always_comb begin
        cnt_nxt = cnt;
        do_nxt  = d_o;
        if (mode != mode_r) begin
            cnt_nxt = '0;
        end else if (!ena) begin
            cnt_nxt = '0;
            do_nxt  = s;
        end else if (mode == LOCKOUT) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - ONE;
            end else if (s != d_o) begin
                do_nxt  = s;
                cnt_nxt = len;
            end
        end else begin
            // >= so a len lowered below the running count fires on the next differing cycle
            if (s == d_o) begin
                cnt_nxt = '0;
            end else if (cnt >= len) begin
                do_nxt  = s;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SS{DI}};
            cnt    <= '0;
            mode_r <= LOCKOUT;
            d_o    <= DI;
            d_p    <= 1'b0;
            d_n    <= 1'b0;
            evt_p  <= 1'b0;
            evt_n  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SS-2:0], d_i};
            cnt    <= cnt_nxt;
            mode_r <= mode;
            d_o    <= do_nxt;
            d_p    <= do_nxt & ~d_o;
            d_n    <= ~do_nxt & d_o;
            evt_p  <= d_p | (evt_p & ~clr);
            evt_n  <= d_n | (evt_n & ~clr);
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N independent debouncer channels with per-channel enable, mode and length.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned    N  = 1,
    parameter int unsigned    CW = 8,
    parameter int unsigned    SS = 2,
    parameter logic [N-1:0]   DI = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         ena,
    input  logic [N-1:0]         mode,
    input  logic [N-1:0][CW-1:0] len,
    input  logic [N-1:0]         clr,
    input  logic [N-1:0]         d_i,
    output logic [N-1:0]         d_o,
    output logic [N-1:0]         d_p,
    output logic [N-1:0]         d_n,
    output logic [N-1:0]         evt_p,
    output logic [N-1:0]         evt_n
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_ch #(
            .CW(CW),
            .SS(SS),
            .DI(DI[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena[i]),
            .mode (mode_t'(mode[i])),
            .len  (len[i]),
            .clr  (clr[i]),
            .d_i  (d_i[i]),
            .d_o  (d_o[i]),
            .d_p  (d_p[i]),
            .d_n  (d_n[i]),
            .evt_p(evt_p[i]),
            .evt_n(evt_n[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with four channels, SS=2, DI=4'b0101.
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned SS = 2;
    localparam logic [N-1:0] DI = 4'b0101;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         ena, mode, clr, d_i;
    logic [N-1:0][CW-1:0] len;
    logic [N-1:0]         d_o, d_p, d_n, evt_p, evt_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_multi #(.N(N), .CW(CW), .SS(SS), .DI(DI)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .mode (mode),
        .len  (len),
        .clr  (clr),
        .d_i  (d_i),
        .d_o  (d_o),
        .d_p  (d_p),
        .d_n  (d_n),
        .evt_p(evt_p),
        .evt_n(evt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = '1; mode = '0; len = '0; clr = '0; d_i = DI;
        #2;
        n_cmp++;
        if ({d_o, d_p, d_n, evt_p, evt_n} !== {DI, 16'b0}) begin
            n_bad++;
            $display("FAIL reset_async: got %b expected %b", {d_o, d_p, d_n, evt_p, evt_n}, {DI, 16'b0});
        end
        repeat (2) tick();
        n_cmp++;
        if ({d_o, d_p, d_n, evt_p, evt_n} !== {DI, 16'b0}) begin
            n_bad++;
            $display("FAIL reset_hold: got %b expected %b", {d_o, d_p, d_n, evt_p, evt_n}, {DI, 16'b0});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({d_o, d_p, d_n, evt_p, evt_n} !== {DI, 16'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got %b expected %b", {d_o, d_p, d_n, evt_p, evt_n}, {DI, 16'b0});
        end
    endtask

    task automatic test_lockout();
        logic [12:1] pat, e_o, e_p;
        pat = 12'b111111110101;
        e_o = 12'b111111111100;
        e_p = 12'b000000000100;
        len[1] = 8'd5;
        for (int k = 1; k <= 12; k++) begin
            d_i[1] = pat[k];
            tick();
            n_cmp++;
            if ({d_o[1], d_p[1], d_n[1]} !== {e_o[k], e_p[k], 1'b0}) begin
                n_bad++;
                $display("FAIL lockout_rise[%0d]: got o/p/n=%b expected %b", k,
                         {d_o[1], d_p[1], d_n[1]}, {e_o[k], e_p[k], 1'b0});
            end
        end
        for (int k = 1; k <= 6; k++) begin
            d_i[1] = 1'b0;
            tick();
            n_cmp++;
            if ({d_o[1], d_p[1], d_n[1]} !== {k < 3, 1'b0, k == 3}) begin
                n_bad++;
                $display("FAIL lockout_fall[%0d]: got o/p/n=%b expected %b", k,
                         {d_o[1], d_p[1], d_n[1]}, {k < 3, 1'b0, k == 3});
            end
            if (k == 3) begin
                n_cmp++;
                if (dut.g_ch[1].u_ch.cnt !== 8'd5) begin
                    n_bad++;
                    $display("FAIL lockout_reload: got cnt=%0d expected 5", dut.g_ch[1].u_ch.cnt);
                end
            end
        end
    endtask

    task automatic test_stable_glitch();
        mode[1] = STABLE;
        len[1]  = 8'd3;
        repeat (3) tick();
        for (int k = 1; k <= 10; k++) begin
            d_i[1] = (k <= 3);
            tick();
            n_cmp++;
            if ({d_o[1], d_p[1], d_n[1]} !== 3'b000) begin
                n_bad++;
                $display("FAIL stable_glitch[%0d]: got o/p/n=%b expected 000", k, {d_o[1], d_p[1], d_n[1]});
            end
        end
    endtask

    task automatic test_stable_accept();
        logic eo, ep, en;
        for (int k = 1; k <= 12; k++) begin
            d_i[1] = (k <= 4);
            tick();
            eo = (k >= 6 && k <= 9);
            ep = (k == 6);
            en = (k == 10);
            n_cmp++;
            if ({d_o[1], d_p[1], d_n[1]} !== {eo, ep, en}) begin
                n_bad++;
                $display("FAIL stable_accept[%0d]: got o/p/n=%b expected %b", k,
                         {d_o[1], d_p[1], d_n[1]}, {eo, ep, en});
            end
        end
    endtask

    task automatic test_ena_off();
        logic eo, ep, en;
        ena[1] = 1'b0;
        len[1] = 8'd200;
        for (int k = 1; k <= 10; k++) begin
            d_i[1] = (k % 2 == 1);
            tick();
            eo = (k >= 3) ? ((k - 2) % 2 == 1) : 1'b0;
            ep = (k >= 3) && eo;
            en = (k >= 4) && !eo;
            n_cmp++;
            if ({d_o[1], d_p[1], d_n[1], dut.g_ch[1].u_ch.cnt} !== {eo, ep, en, 8'd0}) begin
                n_bad++;
                $display("FAIL ena_off[%0d]: got o/p/n/cnt=%b expected %b", k,
                         {d_o[1], d_p[1], d_n[1], dut.g_ch[1].u_ch.cnt}, {eo, ep, en, 8'd0});
            end
        end
        d_i[1] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_mode_switch();
        len[3] = 8'd10;
        d_i[3] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({d_o[3], d_p[3]} !== 2'b11) begin
            n_bad++;
            $display("FAIL mode_lockout_rise: got o/p=%b expected 11", {d_o[3], d_p[3]});
        end
        repeat (3) tick();
        n_cmp++;
        if (dut.g_ch[3].u_ch.cnt !== 8'd7) begin
            n_bad++;
            $display("FAIL mode_pre_cnt: got %0d expected 7", dut.g_ch[3].u_ch.cnt);
        end
        mode[3] = STABLE;
        tick();
        n_cmp++;
        if ({d_o[3], d_p[3], d_n[3], dut.g_ch[3].u_ch.cnt} !== {3'b100, 8'd0}) begin
            n_bad++;
            $display("FAIL mode_switch: got o/p/n/cnt=%b expected %b",
                     {d_o[3], d_p[3], d_n[3], dut.g_ch[3].u_ch.cnt}, {3'b100, 8'd0});
        end
        tick();
        d_i[3] = 1'b0;
        for (int f = 1; f <= 13; f++) begin
            tick();
            n_cmp++;
            if ({d_o[3], d_n[3]} !== {f < 13, f == 13}) begin
                n_bad++;
                $display("FAIL mode_stable_fall[%0d]: got o/n=%b expected %b", f,
                         {d_o[3], d_n[3]}, {f < 13, f == 13});
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_flags();
        d_i[2] = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if ({d_o[2], evt_n} !== {1'b0, 4'b1110}) begin
            n_bad++;
            $display("FAIL flags_evt_n: got o/evt_n=%b expected %b", {d_o[2], evt_n}, {1'b0, 4'b1110});
        end
        d_i[2] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({d_p[2], evt_p} !== {1'b1, 4'b1010}) begin
            n_bad++;
            $display("FAIL flags_pulse: got p/evt_p=%b expected %b", {d_p[2], evt_p}, {1'b1, 4'b1010});
        end
        clr = 4'b0100;
        tick();
        n_cmp++;
        if ({evt_p, evt_n} !== {4'b1110, 4'b1010}) begin
            n_bad++;
            $display("FAIL flags_set_wins: got evt_p/evt_n=%b expected %b", {evt_p, evt_n}, {4'b1110, 4'b1010});
        end
        tick();
        n_cmp++;
        if ({evt_p, evt_n} !== {4'b1010, 4'b1010}) begin
            n_bad++;
            $display("FAIL flags_clear: got evt_p/evt_n=%b expected %b", {evt_p, evt_n}, {4'b1010, 4'b1010});
        end
        clr = '0;
    endtask

    task automatic test_async_reset();
        mode[1] = LOCKOUT;
        ena[1]  = 1'b1;
        len[1]  = 8'd5;
        d_i[1]  = 1'b0;
        repeat (2) tick();
        d_i[1] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if ({d_o[1], dut.g_ch[1].u_ch.cnt} !== {1'b1, 8'd4}) begin
            n_bad++;
            $display("FAIL async_pre: got o/cnt=%b expected %b", {d_o[1], dut.g_ch[1].u_ch.cnt}, {1'b1, 8'd4});
        end
        #1;
        rst = 1'b1;
        d_i = DI;
        #1;
        n_cmp++;
        if ({d_o, d_p, d_n, evt_p, evt_n, dut.g_ch[1].u_ch.cnt} !== {DI, 16'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_mid: got %b expected %b",
                     {d_o, d_p, d_n, evt_p, evt_n, dut.g_ch[1].u_ch.cnt}, {DI, 16'b0, 8'd0});
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({d_o, d_p, d_n} !== {DI, 8'b0}) begin
                n_bad++;
                $display("FAIL async_release[%0d]: got %b expected %b", k, {d_o, d_p, d_n}, {DI, 8'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_lockout();
        test_stable_glitch();
        test_stable_accept();
        test_ena_off();
        test_mode_switch();
        test_flags();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
